// File: rtl/mxn_table_gen.sv
// Multi-cycle builder for the digit-multiple tables MT[k] = k*m and BT[k] = k*b (optionally mod m).
// Each table gets one adder step per cycle. Two combinational read ports expose the finished entries.
module mxn_table_gen #(
   parameter int NBITS    = 4096,
   parameter int PBITS    = 2,
   parameter int REDUCE_B = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NBITS-1:0]       m,
   input  logic [NBITS-1:0]       b,
   output logic                   busy,
   output logic                   done,
   output logic                   tbl_valid,
   input  logic [PBITS-1:0]       rd_m_idx,
   output logic [NBITS+PBITS-1:0] rd_m_data,
   input  logic [PBITS-1:0]       rd_b_idx,
   output logic [NBITS+PBITS-1:0] rd_b_data
);
   localparam int MLSIZE = 2**PBITS;
   localparam int AW     = NBITS + PBITS;
   localparam logic [PBITS-1:0] LAST = PBITS'(MLSIZE - 1);

   typedef enum logic {IDLE, CALC} state_t;

   state_t                     state_q, state_d;
   logic [NBITS-1:0]           m_r_q, m_r_d, b_r_q, b_r_d;
   logic [AW-1:0]              acc_m_q, acc_m_d, acc_b_q, acc_b_d;
   logic [AW-1:0]              sum_b;
   logic [PBITS-1:0]           cnt_q, cnt_d;
   logic                       busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   // Entry 0 stays at its reset value of zero forever; cnt never addresses it.
   logic [MLSIZE-1:0][AW-1:0]  mt_q, mt_d, bt_q, bt_d;

   always_comb begin
      state_d = state_q;
      m_r_d   = m_r_q;
      b_r_d   = b_r_q;
      acc_m_d = acc_m_q;
      acc_b_d = acc_b_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      mt_d    = mt_q;
      bt_d    = bt_q;
      sum_b   = acc_b_q + AW'(b_r_q);
      if (start) begin
         // A start always wins, aborting any run in flight and suppressing its done.
         m_r_d   = m;
         b_r_d   = b;
         acc_m_d = AW'(m);
         acc_b_d = AW'(b);
         cnt_d   = PBITS'(1);
         valid_d = 1'b0;
         busy_d  = 1'b1;
         state_d = CALC;
      end else if (state_q == CALC) begin
         mt_d[cnt_q] = acc_m_q;
         bt_d[cnt_q] = acc_b_q;
         acc_m_d     = acc_m_q + AW'(m_r_q);
         // With b < m the running value stays below m, so one conditional subtract is enough.
         if (REDUCE_B != 0 && sum_b >= AW'(m_r_q))
            acc_b_d = sum_b - AW'(m_r_q);
         else
            acc_b_d = sum_b;
         cnt_d = cnt_q + PBITS'(1);
         if (cnt_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_r_q   <= '0;
         b_r_q   <= '0;
         acc_m_q <= '0;
         acc_b_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         mt_q    <= '0;
         bt_q    <= '0;
      end else begin
         state_q <= state_d;
         m_r_q   <= m_r_d;
         b_r_q   <= b_r_d;
         acc_m_q <= acc_m_d;
         acc_b_q <= acc_b_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         mt_q    <= mt_d;
         bt_q    <= bt_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign tbl_valid = valid_q;
   assign rd_m_data = (valid_q && rd_m_idx != '0) ? mt_q[rd_m_idx] : '0;
   assign rd_b_data = (valid_q && rd_b_idx != '0) ? bt_q[rd_b_idx] : '0;
endmodule
